// File: rtl/ped_walk_scheduler_if.sv
// Signal bundle between the button/vehicle-controller side (master) and ped_walk_scheduler (slave).
// The countdown signal exists only when PED_COUNTDOWN_EN is defined.
interface ped_walk_scheduler_if #(
    parameter int NUM_XW = 4,
    parameter int CW     = 8
);
    logic              tick;
    logic [NUM_XW-1:0] btn;
    logic              safe;
    logic              hold_req;
    logic [NUM_XW-1:0] walk;
    logic [NUM_XW-1:0] dw_flash;
    logic [NUM_XW-1:0] pending;
    logic              busy;
    logic              served;
`ifdef PED_COUNTDOWN_EN
    logic [CW-1:0]     countdown;
`endif

    modport master (
        output tick, btn, safe,
        input  hold_req, walk, dw_flash, pending, busy, served
`ifdef PED_COUNTDOWN_EN
        , input countdown
`endif
    );

    modport slave (
        input  tick, btn, safe,
        output hold_req, walk, dw_flash, pending, busy, served
`ifdef PED_COUNTDOWN_EN
        , output countdown
`endif
    );
endinterface

// File: rtl/ped_walk_scheduler.sv
// Round-robin pedestrian walk scheduler with all-red hold handshake and tick-based phase timers.
// Optional PED_COUNTDOWN_EN adds a countdown output showing the remaining CLEAR ticks.
module ped_walk_scheduler #(
    parameter int NUM_XW  = 4,
    parameter int T_WALK  = 20,
    parameter int T_CLEAR = 10,
    parameter int T_GAP   = 15,
    parameter int CW      = 8
) (
    input  logic               clk,
    input  logic               reset,
    ped_walk_scheduler_if.slave bus
);
    localparam int IW = (NUM_XW > 2) ? $clog2(NUM_XW) : 1;
    localparam int SW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WALK  = 3'd2,
        S_CLEAR = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t            state_r, state_nx_s;
    logic [CW-1:0]     timer_r, timer_nx_s, timer_dec_s;
    logic [IW-1:0]     sel_r, sel_nx_s, rr_ptr_r, rr_nx_s;
    logic [NUM_XW-1:0] btn_q_r, press_s, walk_mask_s, pending_r, pend_nx_s;
    logic              served_nx_s, expire_s;

    // First requesting crossing at or above ptr, wrapping modulo NUM_XW.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_XW-1:0] req, input logic [IW-1:0] ptr);
        logic [IW-1:0] pick;
        logic [SW-1:0] sum;
        logic          found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_XW; i++) begin
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(NUM_XW)) begin
                sum = sum - SW'(NUM_XW);
            end
            if (!found && req[sum[IW-1:0]]) begin
                pick  = sum[IW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_XW-1:0] onehot(input logic [IW-1:0] idx);
        return {{(NUM_XW-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        logic [IW-1:0] nxt;
        if (SW'(idx) == SW'(NUM_XW - 1)) begin
            nxt = {IW{1'b0}};
        end else begin
            nxt = idx + {{(IW-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    assign press_s     = bus.btn & ~btn_q_r;
    assign walk_mask_s = (state_r == S_WALK) ? onehot(sel_r) : {NUM_XW{1'b0}};
    assign timer_dec_s = timer_r - {{(CW-1){1'b0}}, 1'b1};
    assign expire_s    = bus.tick && (timer_r == {{(CW-1){1'b0}}, 1'b1});
    assign bus.pending = pending_r;

    // Next-state, timer and pending-set computation.
    always_comb begin
        state_nx_s  = state_r;
        timer_nx_s  = timer_r;
        sel_nx_s    = sel_r;
        rr_nx_s     = rr_ptr_r;
        served_nx_s = 1'b0;
        // The crossing being walked ignores its own button.
        pend_nx_s   = pending_r | (press_s & ~walk_mask_s);
        case (state_r)
            S_IDLE: begin
                if (|pending_r) begin
                    sel_nx_s   = rr_pick(pending_r, rr_ptr_r);
                    state_nx_s = S_REQ;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.safe) begin
                    state_nx_s       = S_WALK;
                    timer_nx_s       = CW'(T_WALK);
                    pend_nx_s[sel_r] = 1'b0;
                    served_nx_s      = 1'b1;
                    rr_nx_s          = next_idx(sel_r);
                end else begin
                    state_nx_s = S_REQ;
                end
            end
            S_WALK: begin
                // Losing all-red aborts the walk and re-queues the crossing.
                if (!bus.safe) begin
                    state_nx_s       = S_CLEAR;
                    timer_nx_s       = CW'(T_CLEAR);
                    pend_nx_s[sel_r] = 1'b1;
                end else if (expire_s) begin
                    state_nx_s = S_CLEAR;
                    timer_nx_s = CW'(T_CLEAR);
                end else if (bus.tick) begin
                    timer_nx_s = timer_dec_s;
                end else begin
                    timer_nx_s = timer_r;
                end
            end
            S_CLEAR: begin
                if (expire_s) begin
                    state_nx_s = S_GAP;
                    timer_nx_s = CW'(T_GAP);
                end else if (bus.tick) begin
                    timer_nx_s = timer_dec_s;
                end else begin
                    timer_nx_s = timer_r;
                end
            end
            S_GAP: begin
                if (expire_s) begin
                    state_nx_s = S_IDLE;
                    timer_nx_s = {CW{1'b0}};
                end else if (bus.tick) begin
                    timer_nx_s = timer_dec_s;
                end else begin
                    timer_nx_s = timer_r;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                timer_nx_s = {CW{1'b0}};
            end
        endcase
    end

    // State registers and lamp outputs decoded from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            timer_r      <= {CW{1'b0}};
            sel_r        <= {IW{1'b0}};
            rr_ptr_r     <= {IW{1'b0}};
            pending_r    <= {NUM_XW{1'b0}};
            btn_q_r      <= {NUM_XW{1'b1}};
            bus.hold_req <= 1'b0;
            bus.walk     <= {NUM_XW{1'b0}};
            bus.dw_flash <= {NUM_XW{1'b0}};
            bus.busy     <= 1'b0;
            bus.served   <= 1'b0;
`ifdef PED_COUNTDOWN_EN
            bus.countdown <= {CW{1'b0}};
`endif
        end else begin
            state_r      <= state_nx_s;
            timer_r      <= timer_nx_s;
            sel_r        <= sel_nx_s;
            rr_ptr_r     <= rr_nx_s;
            pending_r    <= pend_nx_s;
            btn_q_r      <= bus.btn;
            bus.hold_req <= (state_nx_s == S_REQ) || (state_nx_s == S_WALK) || (state_nx_s == S_CLEAR);
            bus.walk     <= (state_nx_s == S_WALK)  ? onehot(sel_nx_s) : {NUM_XW{1'b0}};
            bus.dw_flash <= (state_nx_s == S_CLEAR) ? onehot(sel_nx_s) : {NUM_XW{1'b0}};
            bus.busy     <= (state_nx_s != S_IDLE);
            bus.served   <= served_nx_s;
`ifdef PED_COUNTDOWN_EN
            bus.countdown <= (state_nx_s == S_CLEAR) ? timer_nx_s : {CW{1'b0}};
`endif
        end
    end
endmodule
